// File: rtl/seq_add_multiplier_if.sv
// rtl/seq_add_multiplier_if.sv - operand/result bus between a requester and the repeated-addition multiplier
interface seq_add_multiplier_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic [WIDTH-1:0] data_in;
    logic [WIDTH-1:0] result;
    logic             done;

    // Requester side: issues start and the two serial operands, observes the product
    modport master (
        output start,
        output data_in,
        input  result,
        input  done
    );

    // Multiplier side
    modport slave (
        input  start,
        input  data_in,
        output result,
        output done
    );
endinterface

// File: rtl/seq_add_multiplier.sv
// rtl/seq_add_multiplier.sv - unsigned multiplier computing A*B by B repeated additions of A
module seq_add_multiplier #(
    parameter int WIDTH = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    seq_add_multiplier_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD_A = 3'd1,
        S_LOAD_B = 3'd2,
        S_ACCUM  = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] p_q, p_d;

    logic [WIDTH-1:0] b_dec;
    logic             b_last;
    logic             done_w;

    // Zero detect looks at B-1 so the final addition and the exit to DONE share a cycle
    assign b_dec  = b_q - WIDTH'(1);
    assign b_last = (b_dec == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q <= '0;
            b_q <= '0;
            p_q <= '0;
        end else begin
            a_q <= a_d;
            b_q <= b_d;
            p_q <= p_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d = S_LOAD_A;
                end
            end
            S_LOAD_A: begin
                state_d = S_LOAD_B;
            end
            S_LOAD_B: begin
                if (bus.data_in == '0) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_ACCUM;
                end
            end
            S_ACCUM: begin
                if (b_last) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                // Holding start high parks here; a new run needs start to fall first
                if (!bus.start) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        a_d    = a_q;
        b_d    = b_q;
        p_d    = p_q;
        done_w = 1'b0;
        case (state_q)
            S_LOAD_A: begin
                a_d = bus.data_in;
            end
            S_LOAD_B: begin
                b_d = bus.data_in;
                p_d = '0;
            end
            S_ACCUM: begin
                p_d = p_q + a_q;
                b_d = b_dec;
            end
            S_DONE: begin
                done_w = 1'b1;
            end
            default: begin
                done_w = 1'b0;
            end
        endcase
    end

    assign bus.result = p_q;
    assign bus.done   = done_w;

endmodule

// File: tb/tb_seq_add_multiplier.sv
// tb/tb_seq_add_multiplier.sv - directed self-checking bench for seq_add_multiplier
module tb_seq_add_multiplier;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    seq_add_multiplier_if #(.WIDTH(16)) bus ();

    seq_add_multiplier #(.WIDTH(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs one product from IDLE; wiggle toggles start while it should be ignored
    task automatic run_mul(input string tag, input logic [15:0] a, input logic [15:0] b,
                           input logic [15:0] exp, input bit wiggle);
        int cyc;
        bus.start = 1'b1;
        tick();
        bus.data_in = a;
        if (wiggle) bus.start = 1'b0;
        tick();
        bus.data_in = b;
        tick();
        bus.data_in = 16'hDEAD;
        cyc = 0;
        while (bus.done !== 1'b1 && cyc < 1000) begin
            chk({tag, "_busy_done"}, {31'd0, bus.done}, 32'd0);
            if (wiggle) bus.start = ~bus.start;
            tick();
            cyc++;
        end
        bus.start = 1'b1;
        chk({tag, "_accum_cycles"}, cyc, {16'd0, b});
        chk({tag, "_result"}, {16'd0, bus.result}, {16'd0, exp});
        tick();
        chk({tag, "_hold_done"}, {31'd0, bus.done}, 32'd1);
        chk({tag, "_hold_result"}, {16'd0, bus.result}, {16'd0, exp});
    endtask

    task automatic finish_op(input string tag, input logic [15:0] exp);
        bus.start = 1'b0;
        tick();
        chk({tag, "_done_drop"}, {31'd0, bus.done}, 32'd0);
        chk({tag, "_idle_result"}, {16'd0, bus.result}, {16'd0, exp});
    endtask

    initial begin
        bus.start   = 1'b0;
        bus.data_in = 16'd0;
        #1;
        chk("reset_result", {16'd0, bus.result}, 32'd0);
        chk("reset_done", {31'd0, bus.done}, 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        chk("idle_done", {31'd0, bus.done}, 32'd0);

        run_mul("m30x5", 16'd30, 16'd5, 16'd150, 1'b0);
        tick();
        chk("m30x5_long_hold", {16'd0, bus.result}, 32'd150);
        finish_op("m30x5", 16'd150);

        run_mul("m7x0", 16'd7, 16'd0, 16'd0, 1'b0);
        finish_op("m7x0", 16'd0);

        run_mul("m0x4", 16'd0, 16'd4, 16'd0, 1'b1);
        finish_op("m0x4", 16'd0);

        run_mul("m300x300", 16'd300, 16'd300, 16'd24464, 1'b0);
        finish_op("m300x300", 16'd24464);

        // Abort a 9*10 run after three additions
        bus.start = 1'b1;
        tick();
        bus.data_in = 16'd9;
        tick();
        bus.data_in = 16'd10;
        tick();
        bus.start = 1'b0;
        tick();
        tick();
        tick();
        chk("rst_partial_sum", {16'd0, bus.result}, 32'd27);
        rst_n = 1'b0;
        #1;
        chk("rst_async_result", {16'd0, bus.result}, 32'd0);
        chk("rst_async_done", {31'd0, bus.done}, 32'd0);
        tick();
        chk("rst_held_result", {16'd0, bus.result}, 32'd0);
        rst_n = 1'b1;
        tick();
        tick();
        chk("rst_idle_done", {31'd0, bus.done}, 32'd0);
        chk("rst_idle_result", {16'd0, bus.result}, 32'd0);
        run_mul("m3x4", 16'd3, 16'd4, 16'd12, 1'b0);
        finish_op("m3x4", 16'd12);

        run_mul("m6x7", 16'd6, 16'd7, 16'd42, 1'b0);
        finish_op("m6x7", 16'd42);
        run_mul("m2x3", 16'd2, 16'd3, 16'd6, 1'b0);
        finish_op("m2x3", 16'd6);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
